// File: rtl/one_wire_pkg.sv
// Shared definitions for the one-wire engine arbiter and its requesters.
package one_wire_pkg;

  // Engine operation requested by a sequencer.
  typedef enum logic [1:0] {
    OW_OP_RESET = 2'd0,
    OW_OP_WRITE = 2'd1,
    OW_OP_READ  = 2'd2,
    OW_OP_RSVD  = 2'd3
  } ow_op_e;

  // Common DS18B20 byte commands.
  localparam logic [7:0] OW_CMD_SKIP_ROM       = 8'hCC;
  localparam logic [7:0] OW_CMD_CONVERT_T      = 8'h44;
  localparam logic [7:0] OW_CMD_READ_SCRATCH   = 8'hBE;
  localparam logic [7:0] OW_CMD_WRITE_SCRATCH  = 8'h4E;

  // Latched command payload.
  typedef struct packed {
    ow_op_e     op;
    logic [7:0] data;
  } ow_cmd_t;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_ISSUE,
    ARB_WAIT_END,
    ARB_DONE
  } arb_state_e;

endpackage

// File: rtl/one_wire_arbiter_rr_picker.sv
// Combinational round-robin pick: first requesting index after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  // Scan ptr+1 .. ptr+N modulo N, keeping the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!valid && req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/one_wire_arbiter.sv
// Shares one one-wire byte engine between NREQ requesters with a
// transaction-locked round-robin grant and strobe/busy sequencing.
module one_wire_arbiter
  import one_wire_pkg::*;
#(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned START_TIMEOUT = 1023
) (
  input  logic              CLK_10MHZ,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   cmd_valid,
  input  logic [2*NREQ-1:0] cmd_op,
  input  logic [8*NREQ-1:0] cmd_data,
  output logic [NREQ-1:0]   rsp_done,
  output logic              rsp_err,
  output logic [7:0]        rsp_data,
  output logic              ow_reset,
  output logic              ow_write,
  output logic              ow_read,
  output logic [7:0]        ow_in_byte,
  input  logic [7:0]        ow_out_byte,
  input  logic              ow_busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ow_cmd_t         cmd_q, cmd_d;
  logic            busy_l_q;
  logic            ow_reset_q, ow_reset_d;
  logic            ow_write_q, ow_write_d;
  logic            ow_read_q, ow_read_d;
  logic [NREQ-1:0] rsp_done_q, rsp_done_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      rsp_data_q, rsp_data_d;

  logic [1:0]      op_arr   [NREQ];
  logic [7:0]      data_arr [NREQ];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            busy_rise_c, busy_fall_c, own_req_c, own_valid_c;

  // Split the flattened per-requester command buses.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]   = cmd_op[2*i +: 2];
    assign data_arr[i] = cmd_data[8*i +: 8];
  end

  rr_picker #(.N(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy_rise_c = ow_busy & ~busy_l_q;
  assign busy_fall_c = ~ow_busy & busy_l_q;
  assign own_req_c   = req[owner_q];
  assign own_valid_c = cmd_valid[owner_q];

  // State and output registers.
  always_ff @(posedge CLK_10MHZ or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_q       <= IW'(NREQ - 1);
      cnt_q      <= '0;
      cmd_q      <= '0;
      busy_l_q   <= 1'b0;
      ow_reset_q <= 1'b0;
      ow_write_q <= 1'b0;
      ow_read_q  <= 1'b0;
      rsp_done_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      busy_l_q   <= ow_busy;
      ow_reset_q <= ow_reset_d;
      ow_write_q <= ow_write_d;
      ow_read_q  <= ow_read_d;
      rsp_done_q <= rsp_done_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state: grant, accept command, hold strobe until busy rises, wait for busy to fall.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    ow_reset_d = 1'b0;
    ow_write_d = 1'b0;
    ow_read_d  = 1'b0;
    rsp_done_d = '0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid && !ow_busy) begin
          gnt_d   = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          rr_d    = pick_idx;
          state_d = ARB_OWNED;
        end
      end

      ARB_OWNED: begin
        if (!own_req_c) begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end else if (own_valid_c && !ow_busy) begin
          cmd_d.op   = ow_op_e'(op_arr[owner_q]);
          cmd_d.data = data_arr[owner_q];
          if (cmd_d.op == OW_OP_RSVD) begin
            rsp_done_d = gnt_q;
            rsp_err_d  = 1'b1;
            state_d    = ARB_DONE;
          end else begin
            cnt_d      = '0;
            ow_reset_d = (cmd_d.op == OW_OP_RESET);
            ow_write_d = (cmd_d.op == OW_OP_WRITE);
            ow_read_d  = (cmd_d.op == OW_OP_READ);
            state_d    = ARB_ISSUE;
          end
        end
      end

      ARB_ISSUE: begin
        ow_reset_d = ow_reset_q;
        ow_write_d = ow_write_q;
        ow_read_d  = ow_read_q;
        cnt_d      = cnt_q + CW'(1);
        if (busy_rise_c) begin
          ow_reset_d = 1'b0;
          ow_write_d = 1'b0;
          ow_read_d  = 1'b0;
          cnt_d      = '0;
          state_d    = ARB_WAIT_END;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          ow_reset_d = 1'b0;
          ow_write_d = 1'b0;
          ow_read_d  = 1'b0;
          cnt_d      = '0;
          if (own_req_c) begin
            rsp_done_d = gnt_q;
            rsp_err_d  = 1'b1;
            state_d    = ARB_DONE;
          end else begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end
      end

      ARB_WAIT_END: begin
        if (busy_fall_c) begin
          if (own_req_c) begin
            rsp_done_d = gnt_q;
            rsp_data_d = (cmd_q.op == OW_OP_READ) ? ow_out_byte : 8'h00;
            state_d    = ARB_DONE;
          end else begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end
      end

      ARB_DONE: begin
        if (own_req_c) begin
          state_d = ARB_OWNED;
        end else begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign gnt        = gnt_q;
  assign rsp_done   = rsp_done_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign ow_reset   = ow_reset_q;
  assign ow_write   = ow_write_q;
  assign ow_read    = ow_read_q;
  assign ow_in_byte = cmd_q.data;

endmodule

// File: doc/one_wire_arbiter.md
Name: one_wire_arbiter

Overview:
- Shares one one_wire byte engine (bus reset / byte write / byte read, busy handshake) between NREQ requesters, e.g. two dallas18b20Ctrl-style sensor sequencers or a sensor poller plus a ROM-search block.
- Requesters hold a round-robin, transaction-locked grant.
- The block sequences the engine's strobe/busy handshake per command and returns a one-cycle done pulse with read data.
- It sits between the requester FSMs and the single one_wire instance on the shared pin.

Parameters:
- NREQ, 2, number of requesters (2..4).
- START_TIMEOUT, 1023, CLK_10MHZ cycles allowed for ow_busy to rise after a strobe is asserted.

Ports:
- CLK_10MHZ  in  1  system clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester bus-ownership request; held for the whole transaction.
- gnt  out  NREQ  one-hot grant; at most one bit set.
- cmd_valid  in  NREQ  per-requester command strobe; honoured only from the granted requester.
- cmd_op  in  2*NREQ  per-requester op: 0 bus reset, 1 write byte, 2 read byte, 3 reserved.
- cmd_data  in  8*NREQ  per-requester write byte.
- rsp_done  out  NREQ  one-cycle completion pulse to the owner.
- rsp_err  out  1  valid with rsp_done; 1 = timeout or reserved op.
- rsp_data  out  8  valid with rsp_done; read byte for op 2, else 0.
- ow_reset, ow_write, ow_read  out  1 each  engine strobes.
- ow_in_byte  out  8  byte to engine.
- ow_out_byte  in  8  byte from engine.
- ow_busy  in  1  engine busy.

Behaviour:
- Reset value of all outputs is 0, including gnt, strobes, rsp_*, ow_in_byte. Reset also sets state to IDLE, rr pointer to NREQ-1, busy_l to 0 and the timeout counter to 0. Reset is legal mid-operation: strobes drop immediately.
- busy_l is ow_busy registered each cycle. start = ow_busy & ~busy_l; end = ~ow_busy & busy_l.
- IDLE:
  - Waits until any req is set and ow_busy==0. The busy check covers an engine still running after rst.
  - Grants the first requesting index after rr pointer, wrapping modulo NREQ.
  - gnt is set the cycle after req is sampled. rr pointer is updated to the granted index.
  - Goes to OWNED.
- OWNED:
  - If req[owner]==0, clear gnt and return to IDLE. Next grant is earliest one cycle later.
  - Else if cmd_valid[owner]:
    - Latch op and data.
    - Op 3: go to DONE with err=1, no engine activity.
    - Otherwise go to ISSUE.
  - cmd_valid from non-owners is ignored, with no response.
- ISSUE:
  - Hold exactly one strobe high: ow_reset (op0), ow_write (op1) or ow_read (op2). ow_in_byte = latched data.
  - Increment the counter each cycle.
  - On start: drop the strobe, clear the counter, go to WAIT_END.
  - If the counter reaches START_TIMEOUT first: drop the strobe, go to DONE with err=1.
- WAIT_END:
  - On end: capture rsp_data = ow_out_byte for op2, else 0. Go to DONE.
  - No timeout in this state; the engine guarantees termination.
- DONE:
  - rsp_done[owner]=1 for exactly one cycle, with rsp_err and rsp_data.
  - Then return to OWNED, or to IDLE if req[owner] has dropped.
- req deasserted during ISSUE or WAIT_END: the engine op completes normally and the arbiter returns to IDLE without the done pulse. The bus is never abandoned mid-slot.
- Simultaneous requests: the rr pointer decides, so the owner just served has the lowest priority.
- Done-to-next-command: a requester may assert cmd_valid the cycle rsp_done is seen. It is accepted the following cycle, in OWNED.
- A command is never accepted while the engine is busy.
- gnt stays stable between OWNED entry and release; it never changes owner without passing through IDLE.

Decomposition:
- Shared package one_wire_pkg:
  - op codes OW_OP_RESET/WRITE/READ/RSVD.
  - Byte commands 8'hCC, 8'h44, 8'hBE, 8'h4E.
  - State encodings for this FSM.
- One natural sub-module, rr_picker: combinational round-robin selection from req and the pointer. It is reusable by other shared-resource blocks.

Test Plan:
- Single requester: req[0]=1 → gnt=2'b01 next cycle. Send cmd op1 0xCC; the engine model raises busy after 60 cycles for 480 cycles → ow_write is high until busy rises, then rsp_done[0] pulses once with err=0 and data=0.
- Read: op2 with the model returning 0x5A → rsp_data=0x5A with rsp_done[0]; ow_read is deasserted on the busy rising edge.
- Contention: req=2'b11 from reset → gnt[0] first; after req[0] drops → gnt[1]. With req[0] reasserted and req[1] released → gnt[0]. Never two bits set at once.
- Timeout: the model never raises busy → after 1023 cycles the strobe drops, rsp_done pulses with err=1, and the next command is accepted normally.
- Abort: drop req[1] during WAIT_END → no rsp_done[1]; gnt clears only after busy falls; a pending req[0] is granted the cycle after.
- Async reset: assert rst during ISSUE → strobes and gnt are 0 in the same cycle. After release with ow_busy still high, no grant until ow_busy falls. A reserved op3 → immediate err done with no strobes.
